vrf_write_arbiter: RTL and testbench

//  Merges the two writeback streams of a vector lane into the single VRF write port.

---
 rtl/vrf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_vrf_write_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vrf_write_arbiter.sv
// Merges execution writebacks and load returns onto the single VRF write port.
// Execution wins; displaced loads wait in a small in-order queue.
module vrf_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int LQ_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_we,
  input  logic [4:0]                    ex_dest,
  input  logic [DATA_WIDTH-1:0]         ex_data,
  input  logic                          ex_masked,
  input  logic [2:0]                    ex_sew,
  input  logic [DATA_WIDTH/8-1:0]       ex_mask,
  input  logic                          ld_valid,
  input  logic [4:0]                    ld_dest,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          ld_ready,
  output logic                          vrf_we,
  output logic [4:0]                    vrf_addr,
  output logic [DATA_WIDTH-1:0]         vrf_data,
  output logic [DATA_WIDTH/8-1:0]       vrf_be,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count,
  output logic                          lq_overflow
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic [LQ_DEPTH-1:0][4:0]            lq_dest_q;
  logic [LQ_DEPTH-1:0][DATA_WIDTH-1:0] lq_data_q;
  logic [PW-1:0]                       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                ovf_q;
  logic                                we_q, we_d;
  logic [4:0]                          addr_q, addr_d;
  logic [DATA_WIDTH-1:0]               data_q, data_d;
  logic [NB-1:0]                       be_q, be_d, ex_be;
  logic                                lq_empty, push, pop;

  assign lq_empty = (cnt_q == '0);
  assign ld_ready = (cnt_q < CW'(LQ_DEPTH)) | ~ex_we;
  // While a pop happens the load must go behind the queued ones, never around them.
  assign push     = ld_valid & ld_ready & (ex_we | ~lq_empty);
  assign pop      = ~ex_we & ~lq_empty;

  always_comb begin
    ex_be = '1;
    if (ex_masked && !ex_sew[2]) begin
      for (int b = 0; b < NB; b++) begin
        case (ex_sew[1:0])
          2'd0: ex_be[b] = ex_mask[b];
          2'd1: ex_be[b] = ex_mask[b/2];
          2'd2: ex_be[b] = ex_mask[b/4];
          2'd3: ex_be[b] = ex_mask[b/8];
        endcase
      end
    end
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (ex_we) begin
      we_d   = 1'b1;
      addr_d = ex_dest;
      data_d = ex_data;
      be_d   = ex_be;
    end else if (!lq_empty) begin
      we_d   = 1'b1;
      addr_d = lq_dest_q[rd_ptr_q];
      data_d = lq_data_q[rd_ptr_q];
      be_d   = '1;
    end else if (ld_valid) begin
      we_d   = 1'b1;
      addr_d = ld_dest;
      data_d = ld_data;
      be_d   = '1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_q | (ld_valid & ~ld_ready);
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_dest_q[wr_ptr_q] <= ld_dest;
      lq_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign vrf_we      = we_q;
  assign vrf_addr    = addr_q;
  assign vrf_data    = data_q;
  assign vrf_be      = be_q;
  assign lq_count    = cnt_q;
  assign lq_overflow = ovf_q;
endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed bench for vrf_write_arbiter: exec, bypass, collision, masking, overflow, reset.
module tb_vrf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we, ex_masked, ld_valid;
  logic [4:0]  ex_dest, ld_dest;
  logic [63:0] ex_data, ld_data;
  logic [2:0]  ex_sew;
  logic [7:0]  ex_mask;
  logic        ld_ready, vrf_we, lq_overflow;
  logic [4:0]  vrf_addr;
  logic [63:0] vrf_data;
  logic [7:0]  vrf_be;
  logic [2:0]  lq_count;

  int checks = 0;
  int errors = 0;

  vrf_write_arbiter #(.DATA_WIDTH(64), .LQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_we(ex_we), .ex_dest(ex_dest), .ex_data(ex_data), .ex_masked(ex_masked),
    .ex_sew(ex_sew), .ex_mask(ex_mask),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_data(vrf_data), .vrf_be(vrf_be),
    .lq_count(lq_count), .lq_overflow(lq_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_we = 0; ex_masked = 0; ex_sew = 0; ex_mask = 0; ex_dest = 0; ex_data = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
  endtask

  task automatic exw(input logic [4:0] d, input logic [63:0] v, input logic m,
                     input logic [2:0] s, input logic [7:0] k);
    ex_we = 1; ex_dest = d; ex_data = v; ex_masked = m; ex_sew = s; ex_mask = k;
  endtask

  task automatic ldw(input logic [4:0] d, input logic [63:0] v);
    ld_valid = 1; ld_dest = d; ld_data = v;
  endtask

  task automatic out(input string tag, input logic w, input logic [4:0] a,
                     input logic [63:0] v, input logic [7:0] b, input logic [2:0] c);
    chk({tag, ".we"}, 64'(vrf_we), 64'(w));
    chk({tag, ".addr"}, 64'(vrf_addr), 64'(a));
    chk({tag, ".data"}, vrf_data, v);
    chk({tag, ".be"}, 64'(vrf_be), 64'(b));
    chk({tag, ".cnt"}, 64'(lq_count), 64'(c));
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    out("rst", 0, 0, 0, 8'h00, 0);
    chk("rst.ovf", 64'(lq_overflow), 0);
    @(posedge clk); #1; rst = 0;

    // exec only
    exw(3, 64'hA5, 0, 0, 0);
    tick(); out("exec", 1, 3, 64'hA5, 8'hFF, 0);
    idle();

    // bypass, then hold on idle
    ldw(7, 64'h77);
    #1 chk("byp.rdy", 64'(ld_ready), 1);
    tick(); out("byp", 1, 7, 64'h77, 8'hFF, 0);
    idle();
    tick(); out("hold", 0, 7, 64'h77, 8'hFF, 0);

    // collision, then pop+push keeps order
    exw(1, 64'h11, 0, 0, 0); ldw(9, 64'h99);
    tick(); out("coll", 1, 1, 64'h11, 8'hFF, 1);
    idle(); ldw(10, 64'hAA);
    tick(); out("coll.pop", 1, 9, 64'h99, 8'hFF, 1);
    idle();
    tick(); out("coll.next", 1, 10, 64'hAA, 8'hFF, 0);
    tick(); chk("coll.idle", 64'(vrf_we), 0);

    // masking
    exw(2, 64'h5, 1, 1, 8'h05); tick(); out("m.sew1", 1, 2, 64'h5, 8'h33, 0);
    exw(2, 64'h5, 1, 2, 8'h05); tick(); out("m.sew2", 1, 2, 64'h5, 8'h0F, 0);
    exw(2, 64'h5, 1, 0, 8'h05); tick(); out("m.sew0", 1, 2, 64'h5, 8'h05, 0);
    exw(2, 64'h5, 1, 3, 8'h05); tick(); out("m.sew3", 1, 2, 64'h5, 8'hFF, 0);
    exw(4, 64'h6, 1, 3, 8'h02); tick(); out("m.zero", 1, 4, 64'h6, 8'h00, 0);
    exw(5, 64'h7, 1, 5, 8'h00); tick(); out("m.sew5", 1, 5, 64'h7, 8'hFF, 0);
    exw(6, 64'h8, 1, 1, 8'hF0); tick(); out("m.hibits", 1, 6, 64'h8, 8'h00, 0);
    idle();

    // fill and overflow
    for (int i = 0; i < 6; i++) begin
      exw(5'(i), 64'(i), 0, 0, 0); ldw(5'(20 + i), 64'(16'hD00 + i));
      #1 chk($sformatf("full.rdy%0d", i), 64'(ld_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
      chk($sformatf("full.cnt%0d", i), 64'(lq_count), (i < 4) ? 64'(i + 1) : 64'd4);
    end
    chk("full.ovf", 64'(lq_overflow), 1);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick(); out($sformatf("drain%0d", i), 1, 5'(20 + i), 64'(16'hD00 + i), 8'hFF, 3'(3 - i));
    end
    tick(); chk("drain.idle", 64'(vrf_we), 0);
    chk("ovf.sticky", 64'(lq_overflow), 1);

    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      exw(1, 64'h1, 0, 0, 0); ldw(5'(10 + i), 64'hE0);
      tick();
    end
    chk("pre.cnt", 64'(lq_count), 3);
    idle();
    #1 rst = 1;
    #1;
    out("midrst", 0, 0, 0, 8'h00, 0);
    chk("midrst.ovf", 64'(lq_overflow), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); out($sformatf("post%0d", i), 0, 0, 0, 8'h00, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
